clk_div_bank: RTL

- Parametrised multi-channel clock-enable/divided-clock generator running on the board reference clock.
- Successor to the fixed two-output clock block. Adds:
  - N channels;
  - runtime-programmable divisor and phase lag per channel;
  - lock sequencer with a `locked` flag;
  - a config-load handshake.
- Feeds ADC sample strobes and display/capture timing logic.

---
 rtl/clk_div_bank_pkg.sv | 31 +++
 rtl/clk_div_bank_if.sv | 28 ++
 rtl/clk_div_bank_chan.sv | 90 +++++++++
 rtl/clk_div_bank.sv | 123 ++++++++++++
 4 files changed

// File: rtl/clk_div_bank_pkg.sv
// Shared types and constants for the clk_div_bank clock-enable generator.
package clk_div_bank_pkg;

  // Field width of the stored channel configuration.
  localparam int DIV_W = 8;

  // Configuration every channel takes after reset.
  localparam int DEF_DIV   = 5;
  localparam int DEF_PHASE = 0;

  // Bank sequencer states.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RUN       = 2'd1,
    RELOCK    = 2'd2
  } state_t;

  // Per-channel operating mode.
  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_DELAY = 2'd1,
    CH_RUN   = 2'd2
  } chan_mode_t;

  // Stored configuration of one channel.
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] phase;
  } cfg_t;

endpackage

// File: rtl/clk_div_bank_if.sv
// Config-load handshake, status flags and channel outputs of clk_div_bank.
interface clk_div_bank_if #(
  parameter int N_CH  = 2,
  parameter int DIV_W = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_load;
  logic [CH_W-1:0]  cfg_chan;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic             cfg_busy;
  logic             locked;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  clk_en_out;

  // Configuration source (host / bench side).
  modport master (
    output cfg_load, cfg_chan, cfg_div, cfg_phase,
    input  cfg_busy, locked, clk_out, clk_en_out
  );

  // Clock generator side.
  modport slave (
    input  cfg_load, cfg_chan, cfg_div, cfg_phase,
    output cfg_busy, locked, clk_out, clk_en_out
  );
endinterface

// File: rtl/clk_div_bank_chan.sv
// One divider channel: phase-lag delay counter, period counter and
// registered clk_out / clk_en_out. A divisor of 0 keeps the channel silent.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             refclk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             clk_out,
  output logic             clk_en_out
);

  chan_mode_t       mode, mode_nxt;
  logic [DIV_W-1:0] dly, dly_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic             clk_nxt, en_nxt;

  logic             div_on;
  logic [DIV_W-1:0] last;
  logic [DIV_W:0]   half;

  // Period end and high-phase length; one extra bit keeps ceil(255/2) exact.
  assign div_on = (div != '0);
  assign last   = div - DIV_W'(1);
  assign half   = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;

  // Next mode and counters; outputs are derived from the next count so the
  // registered outputs show c=0 in the very first running cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    mode_nxt = mode;
    dly_nxt  = dly;
    cnt_nxt  = cnt;
    if (stop) begin
      mode_nxt = CH_IDLE;
      dly_nxt  = '0;
      cnt_nxt  = '0;
    end else if (start) begin
      cnt_nxt = '0;
      if (phase == '0) begin
        mode_nxt = CH_RUN;
      end else begin
        mode_nxt = CH_DELAY;
        dly_nxt  = phase;
      end
    end else begin
      unique case (mode)
        CH_DELAY: begin
          if (dly == DIV_W'(1)) begin
            mode_nxt = CH_RUN;
            cnt_nxt  = '0;
          end else begin
            dly_nxt = dly - DIV_W'(1);
          end
        end
        CH_RUN: begin
          if (!div_on || cnt >= last) cnt_nxt = '0;
          else                        cnt_nxt = cnt + DIV_W'(1);
        end
        default: ;
      endcase
    end
    clk_nxt = (mode_nxt == CH_RUN) && div_on && ({1'b0, cnt_nxt} < half);
    en_nxt  = (mode_nxt == CH_RUN) && div_on && (cnt_nxt == last);
  end

  // Channel state and output registers.
  always_ff @(posedge refclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      mode       <= CH_IDLE;
      dly        <= '0;
      cnt        <= '0;
      clk_out    <= 1'b0;
      clk_en_out <= 1'b0;
    end else begin
      mode       <= mode_nxt;
      dly        <= dly_nxt;
      cnt        <= cnt_nxt;
      clk_out    <= clk_nxt;
      clk_en_out <= en_nxt;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel clock-enable / divided-clock generator with a lock sequencer
// and a runtime config-load handshake.
// Optional: CLK_DIV_BANK_SYNC_RESTART_EN -- any accepted load silences every
// channel during RELOCK and restarts all of them together on RUN entry.
module clk_div_bank #(
  parameter int N_CH        = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 64,
  parameter int DEF_DIV     = clk_div_bank_pkg::DEF_DIV,
  parameter int DEF_PHASE   = clk_div_bank_pkg::DEF_PHASE
) (
  input  logic           refclk,
  input  logic           reset,
  clk_div_bank_if.slave  bus
);
  import clk_div_bank_pkg::*;

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_CYCLES - 1);
  // Bit i set when channel index i exists; indexing avoids a range compare
  // that is constant for power-of-two channel counts.
  localparam logic [2**CH_W-1:0] CHAN_OK = (2**CH_W)'((1 << N_CH) - 1);

  // The stored config struct is sized by the package field width.
  if (DIV_W != clk_div_bank_pkg::DIV_W) begin : g_bad_div_w
    $error("clk_div_bank: DIV_W must equal clk_div_bank_pkg::DIV_W");
  end

  state_t           state, state_nxt;
  logic [LCK_W-1:0] lock_cnt;
  logic             lock_done;
  logic             accept;
  cfg_t             cfg [N_CH];
  logic [N_CH-1:0]  start, stop;
  logic [N_CH-1:0]  clk_vec, en_vec;
`ifndef CLK_DIV_BANK_SYNC_RESTART_EN
  logic [CH_W-1:0]  tgt_ch;
`endif

  assign lock_done = (lock_cnt == LOCK_LAST);
  assign accept    = (state == RUN) && bus.cfg_load && CHAN_OK[bus.cfg_chan];

  // State register.
  always_ff @(posedge refclk) begin
    if (reset) state <= WAIT_LOCK;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_LOCK, RELOCK: if (lock_done) state_nxt = RUN;
      RUN:               if (accept)    state_nxt = RELOCK;
      default:           state_nxt = WAIT_LOCK;
    endcase
  end

  // Output logic: status flags and channel start/stop strobes.
  always_comb begin
    bus.locked   = (state == RUN);
    bus.cfg_busy = (state != RUN);
    for (int i = 0; i < N_CH; i++) begin
`ifdef CLK_DIV_BANK_SYNC_RESTART_EN
      stop[i]  = accept;
      start[i] = lock_done && (state != RUN);
`else
      stop[i]  = accept && (bus.cfg_chan == CH_W'(i));
      start[i] = lock_done && ((state == WAIT_LOCK) ||
                               ((state == RELOCK) && (tgt_ch == CH_W'(i))));
`endif
    end
  end

  // Lock counter: runs through WAIT_LOCK / RELOCK, idles at zero in RUN.
  always_ff @(posedge refclk) begin
    if (reset)                          lock_cnt <= '0;
    else if (state != RUN && !lock_done) lock_cnt <= lock_cnt + LCK_W'(1);
    else                                lock_cnt <= '0;
  end

  // Channel configuration, written only by an accepted load.
  always_ff @(posedge refclk) begin
    if (reset) begin
      // NOTE: the config array is a few flops, not a RAM, so it is reset like any other state.
      for (int i = 0; i < N_CH; i++) begin
        cfg[i] <= '{div: DIV_W'(DEF_DIV), phase: DIV_W'(DEF_PHASE)};
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (accept && bus.cfg_chan == CH_W'(i)) begin
          cfg[i] <= '{div: bus.cfg_div, phase: bus.cfg_phase};
        end
      end
    end
  end

`ifndef CLK_DIV_BANK_SYNC_RESTART_EN
  // Remember which channel restarts when RELOCK completes.
  always_ff @(posedge refclk) begin
    if (reset)       tgt_ch <= '0;
    else if (accept) tgt_ch <= bus.cfg_chan;
  end
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_div_chan #(.DIV_W(DIV_W)) u_chan (
      .refclk     (refclk),
      .reset      (reset),
      .start      (start[i]),
      .stop       (stop[i]),
      .div        (cfg[i].div),
      .phase      (cfg[i].phase),
      .clk_out    (clk_vec[i]),
      .clk_en_out (en_vec[i])
    );
  end

  assign bus.clk_out    = clk_vec;
  assign bus.clk_en_out = en_vec;

endmodule
